// File: rtl/dmem_uart_tx.sv
// rtl/dmem_uart_tx.sv - memory-mapped UART transmitter with TX FIFO on the dmem bus.
// Optional even parity bit when UART_TX_PARITY_EN is defined (8E1 instead of 8N1).
module dmem_uart_tx #(
  parameter int              XLen      = 32,
  parameter logic [XLen-1:0] BaseAddr  = 32'h1000_0000,
  parameter int              ClkDiv    = 16,
  parameter int              FifoDepth = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLen-1:0] dmem_addr_i,
  input  logic            dmem_we_i,
  input  logic [XLen-1:0] dmem_wdata_i,
  output logic [XLen-1:0] dmem_rdata_o,
  output logic            sel_o,
  output logic            tx_o
);
  localparam int PtrW  = $clog2(FifoDepth);
  localparam int CntW  = PtrW + 1;
  localparam int BaudW = $clog2(ClkDiv);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t          r_state, w_state_next;
  logic [BaudW-1:0] r_baud;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift, w_shift_next;
  logic             r_tx, w_tx_next;
  logic [7:0]       r_mem [FifoDepth];
  logic [PtrW-1:0]  r_wptr, r_rptr;
  logic [CntW-1:0]  r_count;
  logic             r_ovf;
`ifdef UART_TX_PARITY_EN
  logic             r_parity;
`endif

  logic [1:0]      w_offset;
  logic            w_wr_data, w_wr_ctrl, w_empty, w_full, w_tick;
  logic            w_pop, w_push, w_busy;
  logic [XLen-1:0] w_status;
  logic            w_unused;

  assign w_offset  = dmem_addr_i[3:2];
  assign sel_o     = (dmem_addr_i[XLen-1:4] == BaseAddr[XLen-1:4]);
  assign w_wr_data = sel_o && dmem_we_i && (w_offset == 2'd0);
  assign w_wr_ctrl = sel_o && dmem_we_i && (w_offset == 2'd2) && dmem_wdata_i[0];
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CntW'(FifoDepth));
  assign w_tick    = (r_baud == BaudW'(ClkDiv - 1));
  // A store into a full FIFO still lands if the transmitter frees a slot this same cycle.
  assign w_push    = w_wr_data && (!w_full || w_pop);
  assign w_busy    = (r_state != S_IDLE);
  assign w_unused  = &{1'b0, dmem_addr_i[1:0], dmem_wdata_i[XLen-1:8]};

  always_comb begin
    w_status       = '0;
    w_status[0]    = w_full;
    w_status[1]    = w_empty;
    w_status[2]    = w_busy;
    w_status[3]    = r_ovf;
    w_status[15:8] = 8'(r_count);
  end

  assign dmem_rdata_o = (sel_o && (w_offset == 2'd1)) ? w_status : '0;
  assign tx_o         = r_tx;

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
      if (r_state == S_IDLE || w_state_next == S_IDLE || w_tick) r_baud <= '0;
      else                                                      r_baud <= r_baud + BaudW'(1);
      if (r_state == S_DATA && w_tick) r_bit <= r_bit + 3'd1;
    end
  end

  // FSM: next state and pop decision
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: if (!w_empty) begin
        w_pop        = 1'b1;
        w_state_next = S_START;
      end
      S_START: if (w_tick) w_state_next = S_DATA;
`ifdef UART_TX_PARITY_EN
      S_DATA:   if (w_tick && r_bit == 3'd7) w_state_next = S_PARITY;
      S_PARITY: if (w_tick) w_state_next = S_STOP;
`else
      S_DATA:   if (w_tick && r_bit == 3'd7) w_state_next = S_STOP;
`endif
      S_STOP: if (w_tick) begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs, registered one cycle ahead so tx_o follows the state it enters
  always_comb begin
    w_shift_next = r_shift;
    if (w_pop)                           w_shift_next = r_mem[r_rptr];
    else if (r_state == S_DATA && w_tick) w_shift_next = {1'b0, r_shift[7:1]};
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_next = r_parity;
`endif
      default:  w_tx_next = 1'b1;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)      r_parity <= 1'b0;
    else if (w_pop) r_parity <= ^r_mem[r_rptr];
  end
`endif

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= dmem_wdata_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
      // A dropped byte wins over a simultaneous clear.
      if (w_wr_data && !w_push) r_ovf <= 1'b1;
      else if (w_wr_ctrl)       r_ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dmem_uart_tx.sv
// tb/tb_dmem_uart_tx.sv - directed and random bench for dmem_uart_tx against a queue-based line model.
// The model keeps pending FIFO bytes and a per-cycle queue of expected serial line levels.
module tb_dmem_uart_tx;
  localparam int          XLen      = 32;
  localparam int          ClkDiv    = 4;
  localparam int          FifoDepth = 4;
  localparam logic [31:0] Base      = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        sel;
  logic        tx;

  always #5 clk = ~clk;

  dmem_uart_tx #(
    .XLen(XLen), .BaseAddr(Base), .ClkDiv(ClkDiv), .FifoDepth(FifoDepth)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .dmem_addr_i(addr), .dmem_we_i(we),
    .dmem_wdata_i(wdata), .dmem_rdata_o(rdata), .sel_o(sel), .tx_o(tx)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  bit         line[$];
  bit         ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s       = 32'h0;
    s[0]    = (q.size() == FifoDepth);
    s[1]    = (q.size() == 0);
    s[2]    = (line.size() > 0);
    s[3]    = ovf;
    s[15:8] = 8'(q.size());
    return s;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (a[31:4] == Base[31:4] && a[3:2] == 2'd1) return exp_status();
    return 32'h0;
  endfunction

  task automatic push_frame(input logic [7:0] b);
    repeat (ClkDiv) line.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (ClkDiv) line.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    repeat (ClkDiv) line.push_back(^b);
`endif
    repeat (ClkDiv) line.push_back(1'b1);
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit         hit, pop, set;
    logic [7:0] b;
    if (rst_i) begin
      q.delete();
      line.delete();
      ovf = 1'b0;
      return;
    end
    hit = (addr[31:4] == Base[31:4]);
    pop = (q.size() > 0) && (line.size() <= 1);
    set = 1'b0;
    if (line.size() > 0) void'(line.pop_front());
    if (pop) begin
      b = q.pop_front();
      push_frame(b);
    end
    if (we && hit && addr[3:2] == 2'd0) begin
      if (q.size() < FifoDepth) q.push_back(wdata[7:0]);
      else begin
        ovf = 1'b1;
        set = 1'b1;
      end
    end
    if (we && hit && addr[3:2] == 2'd2 && wdata[0] && !set) ovf = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    check("tx", {31'h0, tx}, {31'h0, (line.size() > 0) ? line[0] : 1'b1});
    check("sel", {31'h0, sel}, {31'h0, addr[31:4] == Base[31:4]});
    check("rdata", rdata, exp_rdata(addr));
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
    we    = w;
    addr  = a;
    wdata = d;
    step();
  endtask

  initial begin
    int r;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_edge();
    rst_i = 1'b0;

    // reset state
    drive(0, Base + 32'h4, 0);
    check("reset_status", rdata, 32'h0000_0002);

    // single byte 0x55, full frame plus idle tail
    drive(1, Base, 32'h55);
    repeat (45) drive(0, Base + 32'h4, 0);

    // burst of six stores into a four-deep FIFO, then overflow clear
    for (int i = 1; i <= 6; i++) drive(1, Base, 32'(i));
    drive(0, Base + 32'h4, 0);
    drive(1, Base + 32'h8, 32'h1);
    repeat (3) drive(0, Base + 32'h4, 0);

    // reset in the middle of a frame with bytes queued
    rst_i = 1'b1;
    drive(0, Base + 32'h4, 0);
    rst_i = 1'b0;
    drive(0, Base + 32'h4, 0);
    check("post_reset_status", rdata, 32'h0000_0002);
    repeat (50) drive(0, Base + 32'h4, 0);

    // store outside the window
    drive(1, 32'h0000_0100, 32'hAA);
    drive(0, 32'h0000_0100, 0);
    repeat (5) drive(0, Base + 32'h4, 0);

    // randomized traffic
    repeat (1500) begin
      r = $urandom_range(0, 199);
      if (r < 10)       drive(1, Base, $urandom);
      else if (r < 12)  for (int k = 0; k < 6; k++) drive(1, Base, $urandom);
      else if (r < 16)  drive(1, Base + 32'h8, $urandom);
      else if (r < 18)  drive(1, Base + 32'hC, $urandom);
      else if (r < 20)  drive(1, Base + 32'h4, $urandom);
      else if (r < 24)  drive(1, {4'h2, 28'($urandom)}, $urandom);
      else if (r == 24) begin
        rst_i = 1'b1;
        drive(0, Base + 32'h4, 0);
        rst_i = 1'b0;
      end else          drive(0, Base + 32'($urandom_range(0, 15)), 0);
    end

    repeat (300) drive(0, Base + 32'h4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
